av2_ctx_access_arbiter: RTL and testbench

- Shares the single port of the AV2 context-probability model between NUM_REQ entropy-coding lanes.
- Each lane issues two kinds of requests: lookups, which return a probability tagged with the lane ID, and updates, which adapt a probability by the coded bit.
- Sequences the model-wide context reset at tile/frame start: drains in-flight traffic, pulses the reset, then resumes arbitration.
- Sits between the lane decoders and av2_context_model.

---
 rtl/av2_ctx_pkg.sv | 18 +
 rtl/av2_rr_arbiter.sv | 45 ++++
 rtl/av2_ctx_access_arbiter.sv | 139 +++++++++++++
 tb/tb_av2_ctx_access_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/av2_ctx_pkg.sv
// Shared types and defaults for the AV2 context-model access arbiter.
package av2_ctx_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_IDX_W        = 16;
    localparam int DEF_PROB_W       = 16;
    localparam int DEF_NUM_CONTEXTS = 1024;
    // Probability every context holds after a model-wide reset.
    localparam int DEF_PROB         = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RESET  = 2'd2,
        ST_RESUME = 2'd3
    } ctx_state_e;

endpackage

// File: rtl/av2_rr_arbiter.sv
// Round-robin grant among N requesters. The pointer names the lane the
// next search starts at; it moves to one past the granted lane whenever a
// grant is issued (a grant is only given to a valid request, so it is an accept).
module av2_rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] ptr;
    logic            found;

    function automatic int wrap_lane(input int lane);
        return (lane >= N) ? lane - N : lane;
    endfunction

    // Scan from the pointer, wrapping once, and grant the first valid lane.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en && !found && req[ID_W'(wrap_lane(int'(ptr) + i))]) begin
                found                                 = 1'b1;
                gnt[ID_W'(wrap_lane(int'(ptr) + i))] = 1'b1;
                gnt_id                                = ID_W'(wrap_lane(int'(ptr) + i));
            end
        end
    end

    // Advance the search start past the lane that was just accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (found)
            ptr <= (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;
    end

endmodule

// File: rtl/av2_ctx_access_arbiter.sv
// Shares the single context-model port between NUM_REQ entropy lanes and
// sequences the model-wide context reset (drain, pulse, resume).
module av2_ctx_access_arbiter
    import av2_ctx_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int PROB_W       = DEF_PROB_W,
    parameter int NUM_CONTEXTS = DEF_NUM_CONTEXTS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_is_upd,
    input  logic [NUM_REQ*IDX_W-1:0]   req_idx,
    input  logic [NUM_REQ-1:0]         req_bit,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [PROB_W-1:0]          resp_prob,
    output logic                       resp_oob,
    output logic [IDX_W-1:0]           ctx_idx,
    input  logic [PROB_W-1:0]          ctx_prob,
    output logic                       upd_en,
    output logic [IDX_W-1:0]           upd_idx,
    output logic                       upd_bit,
    output logic                       ctx_reset,
    input  logic                       reset_req,
    output logic                       busy
);

    localparam int              ID_W      = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]  CTX_LIMIT = (IDX_W + 1)'(NUM_CONTEXTS);

    ctx_state_e                     state, state_nxt;
    logic                           grant_en;
    logic [ID_W-1:0]                gnt_id;
    logic [NUM_REQ-1:0][IDX_W-1:0]  lane_idx;
    logic [IDX_W-1:0]               sel_idx;
    logic                           sel_upd, sel_bit, accept;
    logic                           s1_vld, s1_lookup, s1_oob;
    logic [ID_W-1:0]                s1_id;

    av2_rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (grant_en),
        .req    (req_valid),
        .gnt    (req_ready),
        .gnt_id (gnt_id)
    );

    assign lane_idx = req_idx;
    assign accept   = |req_ready;
    assign sel_idx  = lane_idx[gnt_id];
    assign sel_upd  = req_is_upd[gnt_id];
    assign sel_bit  = req_bit[gnt_id];

    // Stage 1: drive the model port from the accepted request. ctx_idx only
    // moves for lookups so an update leaves the read address untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_lookup <= 1'b0;
            s1_oob    <= 1'b0;
            s1_id     <= '0;
            ctx_idx   <= '0;
            upd_en    <= 1'b0;
            upd_idx   <= '0;
            upd_bit   <= 1'b0;
        end else begin
            s1_vld    <= accept;
            s1_lookup <= accept && !sel_upd;
            upd_en    <= accept && sel_upd;
            if (accept)
                s1_id <= gnt_id;
            if (accept && !sel_upd) begin
                ctx_idx <= sel_idx;
                s1_oob  <= ({1'b0, sel_idx} >= CTX_LIMIT);
            end
            if (accept && sel_upd) begin
                upd_idx <= sel_idx;
                upd_bit <= sel_bit;
            end
        end
    end

    // Stage 2: lookup response tag; the probability arrives from the model
    // register in this same cycle and is passed straight through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_oob   <= 1'b0;
        end else begin
            resp_valid <= s1_lookup;
            if (s1_lookup) begin
                resp_id  <= s1_id;
                resp_oob <= s1_oob;
            end
        end
    end

    assign resp_prob = resp_valid ? ctx_prob : '0;

    // Reset sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Reset sequencer next state; grants are only allowed in IDLE with no
    // pending reset request.
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (reset_req)
                    state_nxt = ST_DRAIN;
                else
                    grant_en = 1'b1;
            end
            ST_DRAIN: begin
                if (!s1_vld && !resp_valid)
                    state_nxt = ST_RESET;
            end
            ST_RESET:  state_nxt = ST_RESUME;
            ST_RESUME: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign ctx_reset = (state == ST_RESET);

endmodule

// File: tb/tb_av2_ctx_access_arbiter.sv
// Self-checking bench: a behavioural context model, a scoreboard that
// predicts grants/updates/responses from the arbitration rules, and
// directed plus randomized stimulus.
module tb_av2_ctx_access_arbiter;
    import av2_ctx_pkg::*;

    localparam int NR  = 4;
    localparam int IW  = DEF_IDX_W;
    localparam int PW  = DEF_PROB_W;
    localparam int NC  = DEF_NUM_CONTEXTS;
    localparam int IDW = $clog2(NR);

    logic              clk, rst_n;
    logic [NR-1:0]     req_valid, req_ready, req_is_upd, req_bit;
    logic [NR*IW-1:0]  req_idx;
    logic              resp_valid, resp_oob;
    logic [IDW-1:0]    resp_id;
    logic [PW-1:0]     resp_prob, ctx_prob;
    logic [IW-1:0]     ctx_idx, upd_idx;
    logic              upd_en, upd_bit, ctx_reset, reset_req, busy;

    av2_ctx_access_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .PROB_W(PW), .NUM_CONTEXTS(NC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_upd(req_is_upd),
        .req_idx(req_idx), .req_bit(req_bit),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_prob(resp_prob), .resp_oob(resp_oob),
        .ctx_idx(ctx_idx), .ctx_prob(ctx_prob),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_bit(upd_bit),
        .ctx_reset(ctx_reset), .reset_req(reset_req), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > (1 << PW) - 1) return (1 << PW) - 1;
        return v;
    endfunction

    // Behavioural context model: registered read, +/-1 adaptation, bulk reset.
    int model_mem [NC];
    always @(posedge clk) begin
        ctx_prob <= (int'(ctx_idx) < NC) ? PW'(model_mem[int'(ctx_idx)]) : PW'(DEF_PROB);
        if (upd_en && int'(upd_idx) < NC)
            model_mem[int'(upd_idx)] <= sat(model_mem[int'(upd_idx)] + (upd_bit ? 1 : -1));
        if (ctx_reset)
            for (int i = 0; i < NC; i++) model_mem[i] <= DEF_PROB;
    end

    // Scoreboard state.
    typedef struct { int due; int id; int prob; bit oob; } rexp_t;
    typedef struct { int due; int idx; bit b; } uexp_t;
    rexp_t         rq[$];
    uexp_t         uq[$];
    int            ref_mem [NC];
    int            rr_next = 0;
    int            cyc = 0;
    int            nreset = 0;
    int            nbusy = 0;
    int            mlane, midx, mprob;
    logic [NR-1:0] last_acc = '0;
    logic [NR-1:0] mon_gnt;

    function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] v, input int start);
        logic [NR-1:0] r = '0;
        for (int i = 0; i < NR; i++)
            if (v[(start + i) % NR]) begin
                r[(start + i) % NR] = 1'b1;
                return r;
            end
        return r;
    endfunction

    // Monitor on the falling edge: grant fairness, update pulses, responses.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            last_acc = '0;
        end else begin
            mon_gnt = (busy || reset_req) ? '0 : rr_pick(req_valid, rr_next);
            chk("grant", req_ready, mon_gnt);
            if (uq.size() > 0 && uq[0].due == cyc) begin
                chk("upd_en", upd_en, 1);
                chk("upd_idx", upd_idx, uq[0].idx);
                chk("upd_bit", upd_bit, uq[0].b);
                void'(uq.pop_front());
            end else
                chk("upd_quiet", upd_en, 0);
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("resp_valid", resp_valid, 1);
                chk("resp_id", resp_id, rq[0].id);
                chk("resp_prob", resp_prob, rq[0].prob);
                chk("resp_oob", resp_oob, rq[0].oob);
                void'(rq.pop_front());
            end else
                chk("resp_quiet", resp_valid, 0);
            if (ctx_reset) begin
                nreset++;
                for (int i = 0; i < NC; i++) ref_mem[i] = DEF_PROB;
            end
            if (busy) nbusy++;
            last_acc = req_valid & req_ready;
            if (|last_acc) begin
                for (int k = 0; k < NR; k++) if (last_acc[k]) mlane = k;
                midx = int'(req_idx[mlane*IW +: IW]);
                if (req_is_upd[mlane]) begin
                    if (midx < NC) ref_mem[midx] = sat(ref_mem[midx] + (req_bit[mlane] ? 1 : -1));
                    uq.push_back('{due: cyc + 1, idx: midx, b: req_bit[mlane]});
                end else begin
                    mprob = (midx < NC) ? ref_mem[midx] : DEF_PROB;
                    rq.push_back('{due: cyc + 2, id: mlane, prob: mprob, oob: (midx >= NC)});
                end
                rr_next = (mlane + 1) % NR;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request on a lane and hold it until accepted.
    task automatic send(input int lane, input bit upd, input int idx, input bit b);
        bit ok = 1'b0;
        req_valid[lane] = 1'b1;
        req_is_upd[lane] = upd;
        req_idx[lane*IW +: IW] = IW'(idx);
        req_bit[lane] = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready[lane];
        end
        chk("send_grant", ok, 1);
        @(posedge clk);
        #1;
        req_valid[lane] = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int id, input int prob, input bit oob);
        bit got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = resp_valid;
        end
        chk({tag, "_valid"}, got, 1);
        chk({tag, "_id"}, resp_id, id);
        chk({tag, "_prob"}, resp_prob, prob);
        chk({tag, "_oob"}, resp_oob, oob);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rvalid"}, resp_valid, 0);
        chk({tag, "_rid"}, resp_id, 0);
        chk({tag, "_rprob"}, resp_prob, 0);
        chk({tag, "_roob"}, resp_oob, 0);
        chk({tag, "_ctxidx"}, ctx_idx, 0);
        chk({tag, "_upd"}, {upd_en, upd_bit, upd_idx}, 0);
        chk({tag, "_ctxrst"}, ctx_reset, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    int            n0, b0;
    logic [NR-1:0] exp_gnt;
    bit            idle_ok;

    initial begin
        for (int i = 0; i < NC; i++) begin
            model_mem[i] = DEF_PROB;
            ref_mem[i]   = DEF_PROB;
        end
        rst_n = 1'b0; req_valid = '0; req_is_upd = '0; req_idx = '0; req_bit = '0; reset_req = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        idle(1);

        // Single lookup: ctx_idx one cycle after accept, response one later.
        send(0, 0, 5, 0);
        @(negedge clk);
        chk("single_ctx_idx", ctx_idx, 5);
        chk("single_upd_en", upd_en, 0);
        @(negedge clk);
        chk("single_rvalid", resp_valid, 1);
        chk("single_rid", resp_id, 0);
        chk("single_rprob", resp_prob, DEF_PROB);

        // Update then back-to-back lookup of the same index sees the new value.
        idle(1);
        send(1, 1, 7, 1);
        send(1, 0, 7, 0);
        @(negedge clk);
        chk("upd_pulse_end", upd_en, 0);
        chk("upd_idx_hold", upd_idx, 7);
        wait_resp("raw", 1, DEF_PROB + 1, 0);

        // Round robin: park the pointer on lane 0, then all lanes hold lookups.
        idle(2);
        send(3, 0, 3, 0);
        for (int k = 0; k < NR; k++) begin
            req_valid[k] = 1'b1; req_is_upd[k] = 1'b0; req_idx[k*IW +: IW] = IW'(20 + k);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_gnt = '0;
            exp_gnt[k % NR] = 1'b1;
            chk("rr_order", req_ready, exp_gnt);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        idle(4);

        // Reset sequence with a lookup in flight.
        for (int k = 0; k < 3; k++) send(0, 1, 9, 1);
        send(1, 0, 9, 0);
        n0 = nreset; b0 = nbusy;
        reset_req = 1'b1;
        @(posedge clk);
        #1;
        reset_req = 1'b0;
        wait_resp("pre_rst", 1, DEF_PROB + 3, 0);
        idle_ok = 1'b0;
        for (int t = 0; t < 20 && !idle_ok; t++) begin
            @(negedge clk);
            idle_ok = !busy;
        end
        chk("busy_release", idle_ok, 1);
        chk("ctx_reset_once", nreset - n0, 1);
        chk("busy_len_ge3", (nbusy - b0) >= 3, 1);
        idle(1);
        send(1, 0, 9, 0);
        wait_resp("post_rst", 1, DEF_PROB, 0);

        // Out-of-range lookup.
        idle(1);
        send(2, 0, 2000, 0);
        wait_resp("oob", 2, DEF_PROB, 1);

        // Level-held reset_req: repeated sequences, no grants meanwhile.
        n0 = nreset;
        reset_req = 1'b1;
        for (int k = 0; k < NR; k++) begin
            req_valid[k] = 1'b1; req_is_upd[k] = 1'b0; req_idx[k*IW +: IW] = IW'(k);
        end
        idle(12);
        chk("held_multi_reset", (nreset - n0) >= 2, 1);
        reset_req = 1'b0;
        idle(6);
        req_valid = '0;
        idle(4);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (last_acc[k] || !req_valid[k]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        req_valid[k]  = 1'b1;
                        req_is_upd[k] = 1'($urandom_range(1, 0));
                        req_bit[k]    = 1'($urandom_range(1, 0));
                        req_idx[k*IW +: IW] = ($urandom_range(9, 0) == 0) ?
                            IW'(NC + $urandom_range(1999, 0)) : IW'($urandom_range(11, 0));
                    end else
                        req_valid[k] = 1'b0;
                end
            end
            reset_req = ($urandom_range(49, 0) == 0);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        reset_req = 1'b0;
        idle(8);

        // Asynchronous reset in the middle of a lookup burst.
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < NR; k++) begin
                req_valid[k] = 1'($urandom_range(1, 0));
                req_is_upd[k] = 1'b0;
                req_idx[k*IW +: IW] = IW'($urandom_range(15, 0));
            end
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk_reset_outputs("async");
        rq.delete();
        uq.delete();
        rr_next = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        send(2, 0, 3, 0);
        wait_resp("after_async", 2, ref_mem[3], 0);

        idle(4);
        chk("scoreboard_empty", rq.size() + uq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
